// File: rtl/bitwise_logic_pipe.sv
// bitwise_logic_pipe
//   Two-stage valid/ready pipeline that applies a bitwise operation to two
//   WIDTH-bit operands. It also keeps a running XOR accumulator for the ACC op.
//
//   Stage S1 holds the accepted operands and op. For ACC, S1 holds the updated
//   accumulator value instead. Stage S2 holds the registered result and flags.
//
// Ports
//   clk        : clock; all state updates on the rising edge
//   rst_n      : asynchronous active-low reset
//   a, b       : operands (WIDTH bits)
//   op         : operation select
//                000 AND, 001 OR, 010 XOR, 011 NAND,
//                100 NOR, 101 XNOR, 110 ANDN (a & ~b), 111 ACC
//   in_valid   : upstream presents a, b and op
//   in_ready   : the block accepts the input this cycle
//   acc_clr    : synchronous accumulator clear
//   result     : operation result (registered, S2)
//   out_zero   : result == 0
//   out_parity : XOR-reduction of result
//   out_valid  : result and flags are valid
//   out_ready  : downstream accepts the output
module bitwise_logic_pipe #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             acc_clr,
  output logic [WIDTH-1:0] result,
  output logic             out_zero,
  output logic             out_parity,
  output logic             out_valid,
  input  logic             out_ready
);

  if (WIDTH < 1 || WIDTH > 64) begin : g_width_check
    $error("bitwise_logic_pipe: WIDTH must be in 1..64");
  end

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_NAND = 3'b011,
    OP_NOR  = 3'b100,
    OP_XNOR = 3'b101,
    OP_ANDN = 3'b110,
    OP_ACC  = 3'b111
  } op_e;

  // Stage S1
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  op_e              s1_op;
  logic [WIDTH-1:0] s1_accv;

  // Accumulator
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_base;
  logic [WIDTH-1:0] acc_upd;

  // Handshake
  logic             s2_adv;
  logic             in_xfer;
  logic             acc_xfer;

  // S1 -> S2 combinational result
  logic [WIDTH-1:0] s1_res;

  assign s2_adv   = !out_valid || out_ready;
  // Gating with rst_n keeps in_ready low for the whole reset period.
  assign in_ready = rst_n && (!s1_valid || s2_adv);
  assign in_xfer  = in_valid && in_ready;
  assign acc_xfer = in_xfer && (op_e'(op) == OP_ACC);

  // The clear is applied before the ACC update in the same cycle.
  assign acc_base = acc_clr ? '0 : acc;
  assign acc_upd  = acc_base ^ a ^ b;

  // The accumulator is updated when the ACC transaction is accepted.
  // S1 therefore carries the post-update value, and later acc_clr pulses
  // cannot reach a transaction that is already in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (acc_xfer) begin
      acc <= acc_upd;
    end else if (acc_clr) begin
      acc <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= OP_AND;
      s1_accv  <= '0;
    end else if (in_xfer) begin
      s1_valid <= 1'b1;
      s1_a     <= a;
      s1_b     <= b;
      s1_op    <= op_e'(op);
      s1_accv  <= acc_upd;
    end else if (s2_adv) begin
      s1_valid <= 1'b0;
    end
  end

  always_comb begin
    s1_res = '0;
    unique case (s1_op)
      OP_AND:  s1_res = s1_a & s1_b;
      OP_OR:   s1_res = s1_a | s1_b;
      OP_XOR:  s1_res = s1_a ^ s1_b;
      OP_NAND: s1_res = ~(s1_a & s1_b);
      OP_NOR:  s1_res = ~(s1_a | s1_b);
      OP_XNOR: s1_res = ~(s1_a ^ s1_b);
      OP_ANDN: s1_res = s1_a & ~s1_b;
      OP_ACC:  s1_res = s1_accv;
      default: s1_res = '0;
    endcase
  end

  // Stage S2: result and flags are registered together, so they always
  // line up with out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      result     <= '0;
      out_zero   <= 1'b0;
      out_parity <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        result     <= s1_res;
        out_zero   <= (s1_res == '0);
        out_parity <= ^s1_res;
      end
    end
  end

endmodule

// File: tb/tb_bitwise_logic_pipe.sv
module tb_bitwise_logic_pipe;

  logic       clk;
  logic       rst_n;
  logic [3:0] a;
  logic [3:0] b;
  logic [2:0] op;
  logic       in_valid;
  logic       in_ready;
  logic       acc_clr;
  logic [3:0] result;
  logic       out_zero;
  logic       out_parity;
  logic       out_valid;
  logic       out_ready;

  int n_checks;
  int n_fail;
  int n_acc;

  bitwise_logic_pipe #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a          (a),
    .b          (b),
    .op         (op),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .acc_clr    (acc_clr),
    .result     (result),
    .out_zero   (out_zero),
    .out_parity (out_parity),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic nedge();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [2:0] o, input logic [3:0] ia, input logic [3:0] ib);
    in_valid = v;
    op       = o;
    a        = ia;
    b        = ib;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] exp_res, input logic exp_zero,
                         input logic exp_par);
    chk({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    chk({tag, "_result"}, {60'd0, result}, {60'd0, exp_res});
    chk({tag, "_zero"}, {63'd0, out_zero}, {63'd0, exp_zero});
    chk({tag, "_parity"}, {63'd0, out_parity}, {63'd0, exp_par});
  endtask

  logic [3:0] sweep_exp [7];
  logic       sweep_par [7];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    n_acc    = 0;
    sweep_exp = '{4'b1000, 4'b1110, 4'b0110, 4'b0111, 4'b0001, 4'b1001, 4'b0100};
    sweep_par = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    rst_n = 1'b0; out_ready = 1'b0; acc_clr = 1'b0;
    drive(1'b0, 3'b000, 4'b0000, 4'b0000);

    // Reset state
    #2;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_result", {60'd0, result}, 64'd0);
    chk("rst_zero", {63'd0, out_zero}, 64'd0);
    chk("rst_parity", {63'd0, out_parity}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    nedge(); nedge();
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", {63'd0, in_ready}, 64'd1);

    // XOR single transaction
    nedge();
    out_ready = 1'b1;
    drive(1'b1, 3'b010, 4'b1101, 4'b0111);
    nedge();
    drive(1'b0, 3'b000, 4'b0000, 4'b0000);
    chk("xor_latency", {63'd0, out_valid}, 64'd0);
    nedge();
    chk_out("xor", 4'b1010, 1'b0, 1'b0);
    // XOR of equal operands
    drive(1'b1, 3'b010, 4'b1010, 4'b1010);
    nedge();
    drive(1'b0, 3'b000, 4'b0000, 4'b0000);
    chk("xor_pulse", {63'd0, out_valid}, 64'd0);
    nedge();
    chk_out("xor_eq", 4'b0000, 1'b1, 1'b0);
    nedge();
    chk("xor_eq_pulse", {63'd0, out_valid}, 64'd0);

    // Back-to-back sweep of op 000..110
    for (int i = 0; i < 9; i++) begin
      if (i >= 2) chk_out($sformatf("sweep%0d", i - 2), sweep_exp[i-2], 1'b0, sweep_par[i-2]);
      if (i < 7) begin
        drive(1'b1, 3'(i), 4'b1100, 4'b1010);
        chk($sformatf("sweep_in_ready%0d", i), {63'd0, in_ready}, 64'd1);
      end else begin
        drive(1'b0, 3'b000, 4'b0000, 4'b0000);
      end
      nedge();
    end
    chk("sweep_drain", {63'd0, out_valid}, 64'd0);

    // Backpressure: out_ready low, three transfers offered
    out_ready = 1'b0;
    drive(1'b1, 3'b000, 4'b1111, 4'b0001);       // t0 -> 0001
    if (in_ready) n_acc++;
    nedge();
    drive(1'b1, 3'b001, 4'b0001, 4'b0010);       // t1 -> 0011
    if (in_ready) n_acc++;
    nedge();
    drive(1'b1, 3'b010, 4'b0110, 4'b0011);       // t2 -> 0101
    if (in_ready) n_acc++;
    chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
    chk_out("bp_head", 4'b0001, 1'b0, 1'b1);
    nedge();
    if (in_ready) n_acc++;
    nedge();
    if (in_ready) n_acc++;
    chk_out("bp_hold", 4'b0001, 1'b0, 1'b1);
    chk("bp_accepted", 64'(n_acc), 64'd2);
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", {63'd0, in_ready}, 64'd1);
    nedge();
    drive(1'b0, 3'b000, 4'b0000, 4'b0000);
    chk_out("bp_t1", 4'b0011, 1'b0, 1'b0);
    nedge();
    chk_out("bp_t2", 4'b0101, 1'b0, 1'b0);
    nedge();
    chk("bp_drain", {63'd0, out_valid}, 64'd0);

    // Accumulator
    drive(1'b1, 3'b111, 4'b0011, 4'b0000);
    nedge();
    drive(1'b1, 3'b111, 4'b0101, 4'b0000);
    nedge();
    drive(1'b0, 3'b000, 4'b0000, 4'b0000);
    acc_clr = 1'b1;                               // 0110 is in S1 here
    chk_out("acc1", 4'b0011, 1'b0, 1'b0);
    nedge();
    acc_clr = 1'b0;
    chk_out("acc2", 4'b0110, 1'b0, 1'b0);
    drive(1'b1, 3'b111, 4'b0001, 4'b0000);
    nedge();
    drive(1'b1, 3'b111, 4'b1000, 4'b0001);
    acc_clr = 1'b1;
    nedge();
    drive(1'b0, 3'b000, 4'b0000, 4'b0000);
    acc_clr = 1'b0;
    chk_out("acc_after_clr", 4'b0001, 1'b0, 1'b1);
    nedge();
    chk_out("acc_clr_coinc", 4'b1001, 1'b0, 1'b0);

    // Reset mid-operation with two transactions in flight
    nedge();
    drive(1'b1, 3'b010, 4'b1111, 4'b0000);
    nedge();
    drive(1'b1, 3'b111, 4'b0111, 4'b0000);
    nedge();
    drive(1'b0, 3'b000, 4'b0000, 4'b0000);
    chk_out("mid_before", 4'b1111, 1'b0, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_out_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_result", {60'd0, result}, 64'd0);
    chk("mid_zero", {63'd0, out_zero}, 64'd0);
    chk("mid_parity", {63'd0, out_parity}, 64'd0);
    chk("mid_in_ready", {63'd0, in_ready}, 64'd0);
    nedge();
    rst_n = 1'b1;
    #1;
    chk("mid_rel_in_ready", {63'd0, in_ready}, 64'd1);
    for (int i = 0; i < 3; i++) begin
      nedge();
      chk($sformatf("mid_no_stale%0d", i), {63'd0, out_valid}, 64'd0);
    end
    // Accumulator starts from zero after reset
    drive(1'b1, 3'b111, 4'b0011, 4'b0000);
    nedge();
    drive(1'b0, 3'b000, 4'b0000, 4'b0000);
    nedge();
    chk_out("mid_acc_zero", 4'b0011, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bitwise_logic_pipe.md
BITWISE_LOGIC_PIPE -- requirements
Module: bitwise_logic_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the operand/result width in bits (legal range 1..64).
REQ-002 SHALL have port clk, input, 1, the single clock; all state SHALL be updated on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-004 SHALL have port a, input, WIDTH, operand A.
REQ-005 SHALL have port b, input, WIDTH, operand B.
REQ-006 SHALL have port op, input, 3, operation select.
REQ-007 SHALL have port in_valid, input, 1, meaning upstream presents a, b and op.
REQ-008 SHALL have port in_ready, output, 1, meaning the block accepts the input this cycle.
REQ-009 SHALL have port acc_clr, input, 1, a synchronous accumulator clear.
REQ-010 SHALL have port result, output, WIDTH, the operation result.
REQ-011 SHALL have port out_zero, output, 1, set when result equals 0.
REQ-012 SHALL have port out_parity, output, 1, the XOR-reduction of result.
REQ-013 SHALL have port out_valid, output, 1, meaning result and flags are valid.
REQ-014 SHALL have port out_ready, input, 1, meaning downstream accepts the output.

Function
REQ-015 SHALL decode op as follows: 000 AND; 001 OR; 010 XOR; 011 NAND; 100 NOR; 101 XNOR; 110 ANDN (a & ~b); 111 ACC.
REQ-016 SHALL apply all operations bitwise over WIDTH bits, with no carries and no width extension.
REQ-017 SHALL define an input transfer as in_valid && in_ready on a rising edge, and an output transfer as out_valid && out_ready.
REQ-018 SHALL be a 2-stage pipeline: stage S1 captures the operands and op, and stage S2 holds the registered result and flags.
REQ-019 SHALL present the result with out_valid asserted on the 2nd rising edge after acceptance when there is no backpressure.
REQ-020 SHALL advance S2 when S2 is empty or when an output transfer occurs in that cycle.
REQ-021 SHALL advance S1 into S2 whenever S2 advances, and S1 SHALL hold its contents otherwise.
REQ-022 SHALL assert in_ready = !S1_valid || S2_advance, i.e. full throughput of 1 transfer per cycle with no bubbles.
REQ-023 SHALL keep result, out_zero and out_parity stable while out_valid && !out_ready.
REQ-024 SHALL deliver results in acceptance order, and no transaction SHALL be dropped or duplicated.
REQ-025 SHALL hold a WIDTH-bit accumulator, acc, for op ACC.
REQ-026 SHALL update acc on an ACC input transfer to acc ^ a ^ b, and that transaction's result SHALL be the updated acc value.
REQ-027 SHALL leave acc unchanged on transfers of any other op.
REQ-028 SHALL clear acc to 0 on acc_clr when no ACC transfer occurs in the same cycle.
REQ-029 SHALL set acc <= a ^ b on acc_clr coincident with an ACC transfer (clear applied first), with result = a ^ b.
REQ-030 SHALL NOT let acc_clr affect transactions already in S1 or S2.
REQ-031 SHALL NOT let a, b, op or acc_clr alter state when in_valid is low, except that acc_clr always clears acc.
REQ-032 SHALL drive out_zero and out_parity from the same registered result, aligned with out_valid.

Reset
REQ-033 SHALL, while rst_n is low, immediately force out_valid=0, result=0, out_zero=0, out_parity=0 and acc=0, and mark S1 and S2 empty, independent of clk.
REQ-034 SHALL hold in_ready at 0 while rst_n is low, and SHALL assert in_ready on the first cycle after rst_n deasserts.
REQ-035 SHALL discard transactions in flight when reset is asserted mid-operation; none SHALL appear after release.

Verification (WIDTH=4)
REQ-036 The bench SHALL cover XOR: a=1101, b=0111, op=010, out_ready=1 -> 2 edges later result=1010, out_zero=0, out_parity=0, out_valid pulses for 1 cycle.
REQ-037 The bench SHALL cover XOR of equal operands: a=1010, b=1010 -> result=0000, out_zero=1, out_parity=0.
REQ-038 The bench SHALL cover a back-to-back sweep: op=000..110 on consecutive cycles with a=1100, b=1010 -> results 1000, 1110, 0110, 0111, 0001, 1001, 0100 in order, with in_ready constantly 1.
REQ-039 The bench SHALL cover backpressure: out_ready=0 with 3 offered transfers -> exactly 2 accepted, then in_ready=0 and result held; after out_ready=1 all 3 results emerge in order.
REQ-040 The bench SHALL cover the accumulator: ACC with (0011,0000), then (0101,0000) -> results 0011, 0110; then acc_clr alone, then ACC with (0001,0000) -> 0001; then acc_clr coincident with ACC (1000,0001) -> 1001.
REQ-041 The bench SHALL cover reset mid-operation: with 2 transactions in flight, assert rst_n low between edges -> out_valid=0 at once and acc=0; after release no stale output appears and in_ready=1.
